// File: rtl/y86_pkg.sv
// Shared definitions for the Y86 condition-code logic.
//   ALU function codes, jXX/cmovXX condition codes, the packed flag
//   register type and its reset value, and a helper that recognises a
//   defined ALU function.
package y86_pkg;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_XOR = 4'h3;

   localparam logic [3:0] C_YES = 4'h0;
   localparam logic [3:0] C_LE  = 4'h1;
   localparam logic [3:0] C_L   = 4'h2;
   localparam logic [3:0] C_E   = 4'h3;
   localparam logic [3:0] C_NE  = 4'h4;
   localparam logic [3:0] C_GE  = 4'h5;
   localparam logic [3:0] C_G   = 4'h6;

   typedef struct packed {
      logic zf;
      logic sf;
      logic of;
   } cc_t;

   localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

   function automatic logic alu_fun_valid(input logic [3:0] fun);
      return fun <= ALU_XOR;
   endfunction

endpackage

// File: rtl/y86_cond_eval.sv
// Combinational branch/cmov condition evaluator.
//   zf, sf, of : condition flags
//   cond_fun   : ifun of the jXX/cmovXX instruction
//   cnd        : 1 when the condition holds; codes 7..15 never hold
module y86_cond_eval
   import y86_pkg::*;
(
   input  logic       zf,
   input  logic       sf,
   input  logic       of,
   input  logic [3:0] cond_fun,
   output logic       cnd
);

   logic lt;

   always_comb begin
      cnd = 1'b0;
      // Signed "less than" survives overflow because OF corrects SF.
      lt  = sf ^ of;
      unique case (cond_fun)
         C_YES:   cnd = 1'b1;
         C_LE:    cnd = lt | zf;
         C_L:     cnd = lt;
         C_E:     cnd = zf;
         C_NE:    cnd = ~zf;
         C_GE:    cnd = ~lt;
         C_G:     cnd = ~lt & ~zf;
         default: cnd = 1'b0;
      endcase
   end

endmodule

// File: rtl/y86_cc_unit.sv
// Architectural condition-code register for the SEQ Y86 execute stage.
//   clk, rst          : clock, synchronous active-high reset
//   alu_a, alu_b      : ALU operands (only sign bits are used)
//   alu_out           : ALU result, B op A
//   alu_fun           : 0 add, 1 sub, 2 and, 3 xor, others reserved
//   set_cc, stat_err  : update request and faulting-instruction block
//   cond_fun          : jXX/cmovXX condition selector
//   zf, sf, of        : registered flags
//   cnd               : condition from the registered flags
//   cc_err            : sticky flag, set_cc seen with a reserved alu_fun
module y86_cc_unit
   import y86_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] alu_a,
   input  logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_out,
   input  logic [3:0]       alu_fun,
   input  logic             set_cc,
   input  logic             stat_err,
   input  logic [3:0]       cond_fun,
   output logic             zf,
   output logic             sf,
   output logic             of,
   output logic             cnd,
   output logic             cc_err
);

   cc_t  cc_q, cc_d;
   logic cc_err_q;
   logic req, upd, bad_fun;
   logic a_msb, b_msb, o_msb;

   // Only the sign bits of the operands matter for overflow.
   logic unused_bits;
   assign unused_bits = ^{alu_a[WIDTH-2:0], alu_b[WIDTH-2:0]};

   always_comb begin
      a_msb   = alu_a[WIDTH-1];
      b_msb   = alu_b[WIDTH-1];
      o_msb   = alu_out[WIDTH-1];
      req     = set_cc & ~stat_err;
      upd     = req & alu_fun_valid(alu_fun);
      bad_fun = req & ~alu_fun_valid(alu_fun);

      cc_d.zf = (alu_out == '0);
      cc_d.sf = o_msb;
      unique case (alu_fun)
         ALU_ADD: cc_d.of = (a_msb == b_msb) & (o_msb != a_msb);
         // B - A overflows only when the operands differ in sign.
         ALU_SUB: cc_d.of = (a_msb != b_msb) & (o_msb != b_msb);
         default: cc_d.of = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cc_q     <= CC_RESET;
         cc_err_q <= 1'b0;
      end else begin
         if (upd) begin
            cc_q <= cc_d;
         end
         if (bad_fun) begin
            cc_err_q <= 1'b1;
         end
      end
   end

   assign zf     = cc_q.zf;
   assign sf     = cc_q.sf;
   assign of     = cc_q.of;
   assign cc_err = cc_err_q;

   y86_cond_eval u_cond_eval (
      .zf       (cc_q.zf),
      .sf       (cc_q.sf),
      .of       (cc_q.of),
      .cond_fun (cond_fun),
      .cnd      (cnd)
   );

endmodule

// File: tb/tb_y86_cc_unit.sv
module tb_y86_cc_unit;

   logic        clk = 1'b0;
   logic        rst, set_cc, stat_err;
   logic [63:0] alu_a, alu_b, alu_out;
   logic [3:0]  alu_fun, cond_fun;
   logic        zf, sf, of, cnd, cc_err;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   y86_cc_unit #(.WIDTH(64)) dut (
      .clk      (clk),
      .rst      (rst),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_out  (alu_out),
      .alu_fun  (alu_fun),
      .set_cc   (set_cc),
      .stat_err (stat_err),
      .cond_fun (cond_fun),
      .zf       (zf),
      .sf       (sf),
      .of       (of),
      .cnd      (cnd),
      .cc_err   (cc_err)
   );

   typedef struct {
      logic        rst, set_cc, stat_err;
      logic [3:0]  fun;
      logic [63:0] a, b, out;
      logic [3:0]  cf;
      logic        chk_pre, pre_cnd;
      logic        zf, sf, of, err, post_cnd;
   } vec_t;

   localparam logic [63:0] Z  = 64'd0;
   localparam logic [63:0] U1 = 64'd1;
   localparam logic [63:0] U5 = 64'd5;
   localparam logic [63:0] A  = 64'h0001_0110_1011_0001;
   localparam logic [63:0] P  = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] N  = 64'h8000_0000_0000_0000;
   localparam logic [63:0] T  = 64'hFFFF_FFFF_FFFF_FFFE;
   localparam logic O = 1'b0;
   localparam logic I = 1'b1;

   vec_t tbl [14];

   // Reference state: true (unbounded) sign of the last flag-setting result.
   logic m_zf, m_sf, m_of, m_lt, m_err;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic ref_cnd(input logic [3:0] cf);
      case (cf)
         4'd0:    return 1'b1;
         4'd1:    return m_lt | m_zf;
         4'd2:    return m_lt;
         4'd3:    return m_zf;
         4'd4:    return ~m_zf;
         4'd5:    return ~m_lt;
         4'd6:    return ~m_lt & ~m_zf;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [63:0] rnd_op();
      case ($urandom_range(0, 5))
         0:       return Z;
         1:       return P;
         2:       return N;
         3:       return '1;
         4:       return U1;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      //           rst set err fun    a   b   out cf     pre   zf sf of er post
      tbl[0]  = '{I, I, O, 4'd0, Z,  Z,  U5, 4'd3, O, O, I, O, O, O, I};
      tbl[1]  = '{I, I, O, 4'd0, Z,  Z,  U5, 4'd3, I, I, I, O, O, O, I};
      tbl[2]  = '{O, I, O, 4'd3, A,  A,  Z,  4'd4, I, O, I, O, O, O, O};
      tbl[3]  = '{O, I, O, 4'd0, P,  P,  T,  4'd2, I, O, O, I, I, O, O};
      tbl[4]  = '{O, O, O, 4'd0, Z,  Z,  Z,  4'd5, I, I, O, I, I, O, I};
      tbl[5]  = '{O, I, I, 4'd0, Z,  Z,  Z,  4'd3, I, O, O, I, I, O, O};
      tbl[6]  = '{O, I, I, 4'd9, Z,  Z,  Z,  4'd0, I, I, O, I, I, O, I};
      tbl[7]  = '{O, I, O, 4'd7, Z,  Z,  Z,  4'd0, I, I, O, I, I, I, I};
      tbl[8]  = '{O, O, O, 4'd0, Z,  Z,  Z,  4'd7, I, O, O, I, I, I, O};
      tbl[9]  = '{O, I, O, 4'd1, U1, N,  P,  4'd6, I, I, O, O, I, I, O};
      tbl[10] = '{O, O, O, 4'd1, U1, N,  P,  4'd1, I, I, O, O, I, I, I};
      tbl[11] = '{O, I, O, 4'd0, Z,  Z,  Z,  4'd3, I, O, I, O, O, I, I};
      tbl[12] = '{O, I, O, 4'd0, P,  P,  T,  4'd3, I, I, O, I, I, I, O};
      tbl[13] = '{I, I, O, 4'd7, P,  P,  T,  4'd3, I, O, I, O, O, O, I};

      rst = 1'b1; set_cc = 1'b0; stat_err = 1'b0; alu_fun = '0; cond_fun = '0;
      alu_a = '0; alu_b = '0; alu_out = '0;

      // Directed sequence: each row is one cycle of stimulus.
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         rst      = tbl[i].rst;
         set_cc   = tbl[i].set_cc;
         stat_err = tbl[i].stat_err;
         alu_fun  = tbl[i].fun;
         alu_a    = tbl[i].a;
         alu_b    = tbl[i].b;
         alu_out  = tbl[i].out;
         cond_fun = tbl[i].cf;
         #1;
         if (tbl[i].chk_pre) chk($sformatf("row%0d cnd_before", i), 64'(cnd), 64'(tbl[i].pre_cnd));
         @(posedge clk);
         #1;
         chk($sformatf("row%0d zf", i), 64'(zf), 64'(tbl[i].zf));
         chk($sformatf("row%0d sf", i), 64'(sf), 64'(tbl[i].sf));
         chk($sformatf("row%0d of", i), 64'(of), 64'(tbl[i].of));
         chk($sformatf("row%0d cc_err", i), 64'(cc_err), 64'(tbl[i].err));
         chk($sformatf("row%0d cnd_after", i), 64'(cnd), 64'(tbl[i].post_cnd));
      end

      // Last row was a reset.
      m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0; m_lt = 1'b0; m_err = 1'b0;

      // Randomised phase against an arithmetic reference model.
      for (int n = 0; n < 400; n++) begin
         logic signed [65:0] sa, sb, t;
         @(negedge clk);
         rst      = ($urandom_range(0, 49) == 0);
         set_cc   = ($urandom_range(0, 3) != 0);
         stat_err = ($urandom_range(0, 7) == 0);
         alu_fun  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15))
                                                : 4'($urandom_range(0, 3));
         cond_fun = 4'($urandom_range(0, 15));
         alu_a    = rnd_op();
         alu_b    = rnd_op();
         sa = {{2{alu_a[63]}}, alu_a};
         sb = {{2{alu_b[63]}}, alu_b};
         case (alu_fun)
            4'd0:    alu_out = alu_b + alu_a;
            4'd1:    alu_out = alu_b - alu_a;
            4'd2:    alu_out = alu_b & alu_a;
            default: alu_out = alu_b ^ alu_a;
         endcase
         case (alu_fun)
            4'd0:    t = sb + sa;
            4'd1:    t = sb - sa;
            default: t = {{2{alu_out[63]}}, alu_out};
         endcase
         #1;
         chk($sformatf("rnd%0d cnd_before", n), 64'(cnd), 64'(ref_cnd(cond_fun)));

         if (rst) begin
            m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0; m_lt = 1'b0; m_err = 1'b0;
         end else if (set_cc && !stat_err) begin
            if (alu_fun <= 4'd3) begin
               m_zf = (alu_out == 64'd0);
               m_sf = alu_out[63];
               // Overflow: the wrapped result differs from the true value.
               m_of = (t != {{2{alu_out[63]}}, alu_out});
               m_lt = t[65];
            end else begin
               m_err = 1'b1;
            end
         end

         @(posedge clk);
         #1;
         chk($sformatf("rnd%0d zf", n), 64'(zf), 64'(m_zf));
         chk($sformatf("rnd%0d sf", n), 64'(sf), 64'(m_sf));
         chk($sformatf("rnd%0d of", n), 64'(of), 64'(m_of));
         chk($sformatf("rnd%0d cc_err", n), 64'(cc_err), 64'(m_err));
         chk($sformatf("rnd%0d cnd_after", n), 64'(cnd), 64'(ref_cnd(cond_fun)));
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/y86_cc_unit.md
Name: y86_cc_unit

Overview:
- Consumer end of the 64-bit ALU datapath (add/sub/and/xor) in the SEQ Y86 processor.
- Latches ZF/SF/OF from each ALU result into the architectural condition-code register when the execute stage enables it.
- Evaluates the Y86 branch/cmov condition (Cnd) from the latched flags for jXX and cmovXX.
- Sits beside the ALU in execute; its Cnd output feeds PC-select and the write-back destination mux.

Parameters:
- WIDTH, 64, ALU operand/result width; sign bit is WIDTH-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- alu_a  in  WIDTH  ALU operand A (valA, or valC for irmovq/opq-immediate paths).
- alu_b  in  WIDTH  ALU operand B (valB).
- alu_out  in  WIDTH  ALU result, computed as B op A.
- alu_fun  in  4  0 = add, 1 = sub (B-A), 2 = and, 3 = xor; others reserved.
- set_cc  in  1  update request from execute (asserted only for OPq).
- stat_err  in  1  current instruction is faulting (ADR/INS/HLT); blocks the update.
- cond_fun  in  4  ifun of the current jXX/cmovXX.
- zf  out  1  registered zero flag.
- sf  out  1  registered sign flag.
- of  out  1  registered overflow flag.
- cnd  out  1  combinational condition result from the registered flags.
- cc_err  out  1  registered; set when set_cc is requested with a reserved alu_fun.

Behaviour:
- Reset, when rst=1 at a clock edge: zf=1, sf=0, of=0, cc_err=0. Reset has priority over every other input.
- Update enable: upd = set_cc & ~stat_err & (alu_fun<=3).
- When upd=1, on the next rising edge:
  - zf <= (alu_out==0)
  - sf <= alu_out[WIDTH-1]
  - of per the overflow rule below.
- When upd=0, the flags hold their value.
- Overflow rule:
  - add: of = (a[msb]==b[msb]) & (out[msb]!=a[msb]).
  - sub (B-A): of = (a[msb]!=b[msb]) & (out[msb]!=b[msb]).
  - and, xor: of = 0.
- Reserved alu_fun with set_cc=1 and stat_err=0: flags hold; cc_err <= 1. cc_err is sticky until reset.
- Latency:
  - Flags are visible one cycle after the set_cc edge.
  - cnd is combinational from the registered flags only, never from the current alu_out. An instruction therefore sees the flags of the previous OPq, as sequential SEQ semantics require.
- cnd by cond_fun:
  - 0: 1
  - 1 (le): (sf^of)|zf
  - 2 (l): sf^of
  - 3 (e): zf
  - 4 (ne): ~zf
  - 5 (ge): ~(sf^of)
  - 6 (g): ~(sf^of)&~zf
  - 7–15: 0
- Simultaneous events:
  - rst with set_cc: reset wins.
  - stat_err with set_cc: no update, cc_err unchanged.
- Reset mid-sequence: flags return to the reset values in the same edge; no partial update.
- Width: no internal arithmetic is recomputed. Flags are derived from alu_out and the operand sign bits only.

Decomposition:
- Shared package y86_pkg holds:
  - ALU function codes (ALU_ADD/SUB/AND/XOR).
  - Condition codes (C_YES, C_LE, C_L, C_E, C_NE, C_GE, C_G).
  - CC reset vector (ZF=1, SF=0, OF=0).
- One natural sub-module: y86_cond_eval, a pure combinational zf/sf/of + cond_fun -> cnd block, reused by the PIPE version.
- The flag register and overflow logic stay in y86_cc_unit.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with set_cc=1 and alu_out=0x5 -> zf=1, sf=0, of=0, cc_err=0; cond_fun=3 gives cnd=1.
2. xor-zero: alu_fun=3, a=b=0x1011010110001, out=0, set_cc=1 -> next cycle zf=1, sf=0, of=0; cond_fun=4 gives cnd=0.
3. Add overflow: alu_fun=0, a=b=0x7FFFFFFF_FFFFFFFF, out=0xFFFFFFFF_FFFFFFFE -> sf=1, of=1, zf=0; cond_fun=2 (l) gives cnd=0, cond_fun=5 (ge) gives cnd=1.
4. Sub overflow: alu_fun=1, a=0x1, b=0x80000000_00000000, out=0x7FFFFFFF_FFFFFFFF -> of=1, sf=0; cond_fun=6 (g) gives cnd=0 and cond_fun=1 (le) gives cnd=1, both from SF^OF=1.
5. Hold and block:
   - After scenario 3, set_cc=0 with out=0 -> flags unchanged.
   - Then set_cc=1 with stat_err=1 and out=0 -> flags unchanged.
   - Then set_cc=1 with alu_fun=7 -> flags unchanged, cc_err=1 from the next cycle onward.
6. Same-cycle semantics: with flags zf=0, drive out=0 with set_cc=1 and cond_fun=3 -> cnd=0 in that cycle and cnd=1 in the next cycle. Also assert rst together with set_cc -> reset values result.
